// File: rtl/int_pkg.sv
// Shared types and default sizing for the interrupt pending controller.
package int_pkg;

  localparam int unsigned N_SRC_DEF = 8;
  localparam int unsigned ID_W_DEF  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

endpackage : int_pkg

// File: rtl/int_pending_ctrl_if.sv
// Pulse/mask/ack bus between interrupt sources, core and the pending controller.
interface int_pending_ctrl_if #(
  parameter int unsigned N_SRC = int_pkg::N_SRC_DEF,
  parameter int unsigned ID_W  = int_pkg::ID_W_DEF
);

  logic [N_SRC-1:0] int_pulse;
  logic             mask_we;
  logic [N_SRC-1:0] mask_wdata;
  logic             ovr_clr;
  logic             ack;
  logic             irq;
  logic [ID_W-1:0]  irq_id;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] overrun;

  modport slave (
    input  int_pulse, mask_we, mask_wdata, ovr_clr, ack,
    output irq, irq_id, pending, mask, overrun
  );

  modport master (
    output int_pulse, mask_we, mask_wdata, ovr_clr, ack,
    input  irq, irq_id, pending, mask, overrun
  );

endinterface : int_pending_ctrl_if

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module int_prio_enc #(
  parameter int unsigned N_SRC = int_pkg::N_SRC_DEF,
  parameter int unsigned ID_W  = int_pkg::ID_W_DEF
) (
  input  logic [N_SRC-1:0] vec_i,
  output logic [ID_W-1:0]  id_c,
  output logic             valid_c
);

  // Scan from the top down so the lowest set bit is the last to write.
  always_comb begin
    id_c    = '0;
    valid_c = 1'b0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        id_c    = ID_W'(i);
        valid_c = 1'b1;
      end
    end
  end

endmodule : int_prio_enc

// File: rtl/int_pending_ctrl.sv
// Sticky pending/overrun capture, enable mask, and IRQ presentation FSM.
module int_pending_ctrl
  import int_pkg::*;
#(
  parameter int unsigned N_SRC = N_SRC_DEF,
  parameter int unsigned ID_W  = ID_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  int_pending_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic             irq_q, irq_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] overrun_q, overrun_d;
  logic [N_SRC-1:0] clr_vec;
  logic [ID_W-1:0]  cand_id;
  logic             cand_valid;

  int_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .vec_i   (pending_q & mask_q),
    .id_c    (cand_id),
    .valid_c (cand_valid)
  );

  // Presentation FSM: pick a candidate, hold it until ack, then force one low cycle.
  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    irq_id_d = irq_id_q;
    clr_vec  = '0;
    case (state_q)
      ST_IDLE: begin
        irq_d = 1'b0;
        if (cand_valid) begin
          state_d  = ST_ASSERT;
          irq_d    = 1'b1;
          irq_id_d = cand_id;
        end
      end
      ST_ASSERT: begin
        irq_d = 1'b1;
        if (bus.ack) begin
          clr_vec = N_SRC'(1) << irq_id_q;
          state_d = ST_GAP;
          irq_d   = 1'b0;
        end
      end
      ST_GAP: begin
        irq_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pending/overrun/mask next values; a new pulse beats a same-cycle clear.
  always_comb begin
    pending_d = (pending_q & ~clr_vec) | bus.int_pulse;
    overrun_d = (bus.ovr_clr ? '0 : overrun_q)
              | (bus.int_pulse & pending_q & ~clr_vec);
    mask_d    = bus.mask_we ? bus.mask_wdata : mask_q;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      overrun_q <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      irq_id_q  <= irq_id_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.irq     = irq_q;
  assign bus.irq_id  = irq_id_q;
  assign bus.pending = pending_q;
  assign bus.mask    = mask_q;
  assign bus.overrun = overrun_q;

endmodule : int_pending_ctrl

// File: tb/tb_int_pending_ctrl.sv
// Scoreboard bench for int_pending_ctrl against a cycle-level behavioural model.
module tb_int_pending_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;

  typedef struct {
    bit          irq;
    bit [IW-1:0] id;
    bit [N-1:0]  pend;
    bit [N-1:0]  msk;
    bit [N-1:0]  ovr;
  } exp_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Behavioural model state
  bit          m_irq;
  int          m_id;
  int          m_quiet;
  bit [N-1:0]  m_pend, m_msk, m_ovr;

  int_pending_ctrl_if #(.N_SRC(N), .ID_W(IW)) bus ();

  int_pending_ctrl #(.N_SRC(N), .ID_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_irq = 0; m_id = 0; m_quiet = 0;
    m_pend = '0; m_msk = '0; m_ovr = '0;
  endtask

  // Advance the model by one clock edge given the inputs seen at that edge.
  task automatic model_step(input bit [N-1:0] p, input bit mwe, input bit [N-1:0] md,
                            input bit oc, input bit a);
    bit [N-1:0] clr;
    bit found;
    clr = '0;
    found = 0;
    if (m_irq && a) clr[m_id] = 1'b1;
    if (m_irq) begin
      if (a) begin
        m_irq   = 0;
        m_quiet = 1;   // one forced-low cycle before re-evaluation
      end
    end else if (m_quiet > 0) begin
      m_quiet--;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (!found && m_pend[i] && m_msk[i]) begin
          found = 1;
          m_id  = i;
        end
      end
      m_irq = found;
    end
    m_ovr  = (oc ? '0 : m_ovr) | (p & m_pend & ~clr);
    m_pend = (m_pend & ~clr) | p;
    if (mwe) m_msk = md;
  endtask

  // Drive one cycle of stimulus; expectation is queued right after the edge.
  task automatic step(input bit [N-1:0] p, input bit mwe, input bit [N-1:0] md,
                      input bit oc, input bit a);
    exp_t e;
    bus.int_pulse  = p;
    bus.mask_we    = mwe;
    bus.mask_wdata = md;
    bus.ovr_clr    = oc;
    bus.ack        = a;
    @(posedge clk);
    model_step(p, mwe, md, oc, a);
    e.irq  = m_irq;
    e.id   = IW'(m_id);
    e.pend = m_pend;
    e.msk  = m_msk;
    e.ovr  = m_ovr;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 0, '0, 0, 0);
  endtask

  // Ack everything the model says is presented until nothing is left to serve.
  task automatic service_all();
    bit done;
    done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      if (!m_irq && m_quiet == 0 && (m_pend & m_msk) == '0) done = 1;
      else step('0, 0, '0, 0, m_irq);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL service_timeout: got pending %0h expected drained", m_pend & m_msk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    bus.int_pulse = '1;
    #1;
    chk("rst_irq",     32'(bus.irq),     32'd0);
    chk("rst_irq_id",  32'(bus.irq_id),  32'd0);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_mask",    32'(bus.mask),    32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    bus.int_pulse = '0;
    reset = 1'b1;
    model_reset();
  endtask

  // Monitor: compare each queued expectation on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("irq",     32'(bus.irq),     32'(e.irq));
      if (e.irq) chk("irq_id", 32'(bus.irq_id), 32'(e.id));
      chk("pending", 32'(bus.pending), 32'(e.pend));
      chk("mask",    32'(bus.mask),    32'(e.msk));
      chk("overrun", 32'(bus.overrun), 32'(e.ovr));
    end
  end

  initial begin
    bit [N-1:0] p;
    reset = 1'b0;
    bus.int_pulse = '0; bus.mask_we = 0; bus.mask_wdata = '0;
    bus.ovr_clr = 0; bus.ack = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_irq",     32'(bus.irq),     32'd0);
    chk("init_irq_id",  32'(bus.irq_id),  32'd0);
    chk("init_pending", 32'(bus.pending), 32'd0);
    chk("init_mask",    32'(bus.mask),    32'd0);
    @(negedge clk);
    #1;
    reset = 1'b1;

    // Single event, ack four cycles after the pulse
    step('0, 1, 8'h01, 0, 0);
    step(8'h01, 0, '0, 0, 0);
    idle(3);
    step('0, 0, '0, 0, 1);
    idle(3);

    // Priority and freeze
    step('0, 1, 8'hFF, 0, 0);
    step(8'h20, 0, '0, 0, 0);
    idle(1);
    step(8'h04, 0, '0, 0, 0);
    idle(2);
    step('0, 0, '0, 0, 1);
    idle(4);
    step('0, 0, '0, 0, 1);
    idle(3);

    // Masking gates selection only
    step('0, 1, 8'h00, 0, 0);
    step(8'h08, 0, '0, 0, 0);
    idle(3);
    step('0, 1, 8'h08, 0, 0);
    idle(3);
    step('0, 0, '0, 0, 1);
    idle(3);

    // Overrun, pulse on the ack cycle, overrun clear
    step('0, 1, 8'h02, 0, 0);
    step(8'h02, 0, '0, 0, 0);
    step(8'h02, 0, '0, 0, 0);
    idle(1);
    step(8'h02, 0, '0, 0, 1);
    step('0, 0, '0, 1, 0);
    service_all();

    // Spurious ack while idle
    step('0, 0, '0, 0, 1);
    idle(2);

    // Async reset in the middle of an assertion
    step('0, 1, 8'h01, 0, 0);
    step(8'h01, 0, '0, 0, 0);
    idle(2);
    do_reset();
    step('0, 1, 8'h01, 0, 0);
    step(8'h01, 0, '0, 0, 0);
    idle(2);
    service_all();

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      p = '0;
      for (int b = 0; b < int'(N); b++) if ($urandom_range(9) == 0) p[b] = 1'b1;
      step(p,
           $urandom_range(19) == 0, N'($urandom),
           $urandom_range(24) == 0,
           m_irq ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0));
      if (c == 1000) do_reset();
    end
    service_all();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d queued expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_int_pending_ctrl

// File: doc/int_pending_ctrl.md
Name: int_pending_ctrl

Overview:
- Receiving end of the single-cycle interrupt pulse interface; one pulse arrives per source event.
- Latches each pulse into a sticky pending bit and applies a per-source enable mask.
- Picks the highest-priority enabled pending source and presents it to the CPU core as a level IRQ plus source ID.
- Holds the IRQ until the core acknowledges it with a one-cycle ack handshake; tracks overruns (a pulse arriving while that source is already pending).

Parameters:
- N_SRC, 8, number of interrupt sources (2..32).
- ID_W, 3, width of source ID; must equal clog2(N_SRC).

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- int_pulse  in  N_SRC  one-cycle event pulses, one bit per source.
- mask_we  in  1  write strobe for enable mask.
- mask_wdata  in  N_SRC  new mask value; bit=1 means source enabled.
- ovr_clr  in  1  one-cycle strobe, clears all overrun bits.
- ack  in  1  one-cycle acknowledge from core for the currently presented ID.
- irq  out  1  level interrupt request to core.
- irq_id  out  ID_W  ID of presented source; valid while irq=1.
- pending  out  N_SRC  raw pending register (read-back).
- mask  out  N_SRC  current enable mask.
- overrun  out  N_SRC  sticky per-source overrun flags.

Behaviour:
- Reset (async, reset=0): pending=0, mask=0 (all disabled), overrun=0, irq=0, irq_id=0, FSM=IDLE.
- Pending bit i:
  - Set on the cycle after int_pulse[i]=1.
  - Cleared only by ack of ID i.
  - Pulse and clear on the same bit in the same cycle: the bit stays set (the new event wins).
- Pending bits latch regardless of mask; the mask gates only IRQ selection.
- Overrun[i] is set when int_pulse[i]=1 while pending[i] is already 1 and bit i is not being cleared that cycle.
- ovr_clr clears all overrun bits; a simultaneous new overrun on bit i wins for that bit.
- mask_we: mask <= mask_wdata next cycle.
- Candidate vector = pending & mask. Priority is fixed: lowest index highest.
- FSM states:
  - IDLE: irq=0. If candidate nonzero, latch irq_id = encoded index, go to ASSERT. Registered, so irq rises 1 cycle after pending is visible, i.e. 2 cycles after the pulse.
  - ASSERT: irq=1, irq_id frozen even if a higher-priority source becomes pending.
    - ack=1: clear pending[irq_id], go to GAP.
    - If the presented source is masked off while in ASSERT, the IRQ stays asserted until ack (no withdrawal).
  - GAP: irq=0 for exactly one cycle so the core sees a deassert edge; then IDLE, which re-evaluates the candidate vector.
- ack in IDLE or GAP is ignored; no state change.
- Back-to-back service: with two sources pending, the second irq rises 3 cycles after the first ack (ack cycle, GAP, IDLE evaluate).
- Reset mid-operation: state and outputs return to reset values immediately; pulses during reset are lost.
- Width rules: irq_id is zero-extended encoder output; N_SRC not a power of 2 is legal, and unused IDs are never produced.

Decomposition:
- Shared package int_pkg: FSM state enum (IDLE, ASSERT, GAP), default N_SRC/ID_W constants.
- Sub-module int_prio_enc: combinational, N_SRC-bit input → ID_W-bit index + valid flag, lowest index wins.
- Pending, mask, overrun registers and FSM stay in int_pending_ctrl.

Test Plan:
- Single event: mask=8'h01, pulse bit0 at cycle t → pending[0]=1 at t+1, irq=1 and irq_id=0 at t+2; ack at t+4 → pending[0]=0, irq=0 at t+5 (GAP) and t+6 (IDLE, no candidate).
- Priority and freeze: mask=8'hFF, pulse bit5, then bit2 while irq_id=5 → irq_id stays 5 until ack. After GAP, irq reasserts with irq_id=2. After the second ack, irq=0.
- Masking: mask=0, pulse bit3 → pending=8'h08, irq stays 0. Write mask=8'h08 → irq=1, irq_id=3 two cycles after mask_we.
- Overrun and simultaneity: pulse bit1 twice while pending → overrun=8'h02. Pulse bit1 on the same cycle as its ack → pending[1] remains 1. ovr_clr → overrun=0.
- Spurious ack: ack while IDLE with pending=0 → no state or register change.
- Async reset: assert reset=0 mid-ASSERT between clock edges → irq=0, pending=0, mask=0 immediately; after release, a fresh pulse is serviced normally.
